// File: rtl/boot_pkg.sv
// Shared types and constants for the boot sequencer: FSM encoding, timing
// constants and counter widths.
package boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CNT_W       = ADDR_W + 1;
  localparam int unsigned FLUSH_CYC   = 2;
  localparam int unsigned FCNT_W      = $clog2(FLUSH_CYC + 1);
  localparam int unsigned TIMEOUT_CYC = 1024;
  localparam int unsigned WDT_W       = $clog2(TIMEOUT_CYC);

endpackage

// File: rtl/boot_wdt.sv
// Idle watchdog for the load phase: counts cycles without a transfer and
// flags the cycle in which the next idle edge would reach TIMEOUT_CYC.
module boot_wdt
  import boot_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) r_cnt <= '0;
    else if (en)    r_cnt <= r_cnt + WDT_W'(1);
  end

  assign expired = (r_cnt == WDT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/boot_seq.sv
// Boot sequencer: streams boot words into the instruction SRAM, flushes,
// then releases the core; aborts on boot_up loss and errors on idle timeout.
module boot_seq
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_up,
  input  logic [7:0]        boot_len,
  input  logic              boot_valid,
  input  logic [DATA_W-1:0] boot_data,
  output logic              boot_ready,
  output logic              imem_web,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_datai,
  output logic              core_rst_n,
  output logic              PC_run,
  output logic              done,
  output logic              err
);

  state_t             r_state, w_next;
  logic               r_boot_up, r_rst_d;
  logic [CNT_W-1:0]   r_cnt, r_last;
  logic [FCNT_W-1:0]  r_fcnt;
  logic               r_boot_ready, r_web, r_core_rst_n, r_pc_run, r_done, r_err;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_datai;

  logic w_start, w_boot, w_xfer, w_abort, w_last, w_wr, w_expired;
  logic w_ready, w_web, w_core_rst_n, w_pc_run, w_done, w_err;

  // r_rst_d masks a boot_up that was already high across reset release
  assign w_start = boot_up & ~r_boot_up & ~r_rst_d;
  assign w_boot  = w_start & ((r_state == S_IDLE) | (r_state == S_RUN));
  assign w_xfer  = (r_state == S_LOAD) & boot_valid & r_boot_ready;
  assign w_abort = ~boot_up & ((r_state == S_LOAD) | (r_state == S_FLUSH));
  assign w_last  = w_xfer & (r_cnt == r_last);
  assign w_wr    = w_xfer & ~w_abort;

  boot_wdt u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     ((r_state != S_LOAD) | w_xfer),
    .en      (r_state == S_LOAD),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_abort)                  w_next = S_IDLE;
        else if (w_last)              w_next = S_FLUSH;
        else if (w_expired && !w_xfer) w_next = S_ERR;
      end
      S_FLUSH: begin
        if (w_abort)                             w_next = S_IDLE;
        else if (r_fcnt == FCNT_W'(FLUSH_CYC))   w_next = S_RUN;
      end
      S_RUN:   if (w_start) w_next = S_LOAD;
      S_ERR:   if (!boot_up) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs follow the next state so they change on the same edge as the FSM
  always_comb begin
    w_ready      = (w_next == S_LOAD);
    w_web        = ~w_wr;
    w_core_rst_n = (w_next == S_RUN);
    w_pc_run     = (w_next == S_RUN);
    w_done       = (w_next == S_RUN);
    w_err        = (w_next == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_boot_up <= 1'b0;
      r_rst_d   <= 1'b1;
      r_cnt     <= '0;
      r_last    <= '0;
      r_fcnt    <= '0;
    end else begin
      r_boot_up <= boot_up;
      r_rst_d   <= 1'b0;
      if (w_boot) begin
        r_cnt  <= '0;
        r_last <= {1'b0, boot_len - 8'd1};
      end else if (w_wr) begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      // The first FLUSH cycle carries the final write, so FLUSH lasts FLUSH_CYC+1
      if (r_state != S_FLUSH) r_fcnt <= '0;
      else                    r_fcnt <= r_fcnt + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_boot_ready <= 1'b0;
      r_web        <= 1'b1;
      r_addr       <= '0;
      r_datai      <= '0;
      r_core_rst_n <= 1'b0;
      r_pc_run     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_boot_ready <= w_ready;
      r_web        <= w_web;
      r_core_rst_n <= w_core_rst_n;
      r_pc_run     <= w_pc_run;
      r_done       <= w_done;
      r_err        <= w_err;
      if (w_wr) begin
        r_addr  <= r_cnt[ADDR_W-1:0];
        r_datai <= boot_data;
      end
    end
  end

  assign boot_ready = r_boot_ready;
  assign imem_web   = r_web;
  assign imem_addr  = r_addr;
  assign imem_datai = r_datai;
  assign core_rst_n = r_core_rst_n;
  assign PC_run     = r_pc_run;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_boot_seq.sv
// Bench for boot_seq: a vector table for the basic boot, hand sequences for
// long loads, timeouts, aborts, re-boot and reset, and a write scoreboard.
module tb_boot_seq;

  logic        clk = 1'b0;
  logic        rst, boot_up, boot_valid;
  logic [7:0]  boot_len;
  logic [31:0] boot_data;
  logic        boot_ready, imem_web, core_rst_n, PC_run, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_datai;

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] sb_q[$];

  always #5 clk = ~clk;

  boot_seq dut (
    .clk(clk), .rst(rst), .boot_up(boot_up), .boot_len(boot_len),
    .boot_valid(boot_valid), .boot_data(boot_data), .boot_ready(boot_ready),
    .imem_web(imem_web), .imem_addr(imem_addr), .imem_datai(imem_datai),
    .core_rst_n(core_rst_n), .PC_run(PC_run), .done(done), .err(err)
  );

  // {boot_ready, imem_web, core_rst_n, PC_run, done, err}
  function automatic logic [5:0] outs();
    return {boot_ready, imem_web, core_rst_n, PC_run, done, err};
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and retire any SRAM write against the scoreboard
  task automatic cyc();
    logic [39:0] e;
    @(posedge clk);
    #1;
    if (imem_web !== 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: web %b addr %h data %h, no write expected",
                 imem_web, imem_addr, imem_datai);
      end else begin
        e = sb_q.pop_front();
        if ({imem_addr, imem_datai} !== e) begin
          n_err++;
          $display("FAIL write_port: got %h expected %h", {imem_addr, imem_datai}, e);
        end
      end
    end
  endtask

  task automatic load_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      boot_valid = 1'b1;
      boot_data  = base + 32'(i);
      sb_q.push_back({8'(i), base + 32'(i)});
      cyc();
    end
  endtask

  task automatic wait_run(input string name, input int limit);
    for (int i = 0; i < limit && done !== 1'b1; i++) cyc();
    chk(name, 40'(outs()), 40'(6'b011110));
  endtask

  typedef struct {
    logic        rst;
    logic        up;
    logic [7:0]  len;
    logic        valid;
    logic [31:0] data;
    logic        push;
    logic [7:0]  addr;
    logic [5:0]  exp;
  } vec_t;

  vec_t vt[13];

  initial begin
    rst = 1'b1; boot_up = 1'b0; boot_len = 8'd0; boot_valid = 1'b0; boot_data = '0;

    vt[0]  = '{1, 0, 8'd0, 0, 32'h0,  0, 8'd0, 6'b010000};  // reset
    vt[1]  = '{1, 1, 8'd0, 0, 32'h0,  0, 8'd0, 6'b010000};  // boot_up high in reset
    vt[2]  = '{0, 1, 8'd4, 0, 32'h0,  0, 8'd0, 6'b010000};  // held through release: no boot
    vt[3]  = '{0, 0, 8'd4, 0, 32'h0,  0, 8'd0, 6'b010000};
    vt[4]  = '{0, 1, 8'd4, 1, 32'h11, 0, 8'd0, 6'b110000};  // rising edge -> LOAD
    vt[5]  = '{0, 1, 8'd4, 1, 32'h11, 1, 8'd0, 6'b100000};
    vt[6]  = '{0, 1, 8'd4, 1, 32'h22, 1, 8'd1, 6'b100000};
    vt[7]  = '{0, 1, 8'd4, 1, 32'h33, 1, 8'd2, 6'b100000};
    vt[8]  = '{0, 1, 8'd4, 1, 32'h44, 1, 8'd3, 6'b000000};  // last word, ready drops
    vt[9]  = '{0, 1, 8'd4, 1, 32'h55, 0, 8'd0, 6'b010000};
    vt[10] = '{0, 1, 8'd4, 0, 32'h55, 0, 8'd0, 6'b010000};
    vt[11] = '{0, 1, 8'd4, 0, 32'h55, 0, 8'd0, 6'b011110};  // RUN 3 edges after last write
    vt[12] = '{0, 0, 8'd4, 0, 32'h55, 0, 8'd0, 6'b011110};  // falling boot_up ignored

    for (int i = 0; i < 13; i++) begin
      rst = vt[i].rst; boot_up = vt[i].up; boot_len = vt[i].len;
      boot_valid = vt[i].valid; boot_data = vt[i].data;
      if (vt[i].push) sb_q.push_back({vt[i].addr, vt[i].data});
      cyc();
      chk($sformatf("vec%0d", i), 40'(outs()), 40'(vt[i].exp));
    end

    // Re-boot from RUN with two words
    boot_up = 1'b1; boot_len = 8'd2; boot_valid = 1'b0;
    cyc();
    chk("reboot_release_drop", 40'(outs()), 40'(6'b110000));
    load_words(2, 32'hA0);
    boot_valid = 1'b0;
    wait_run("reboot_run", 10);

    // 256-word boot with valid held afterwards to expose any wrap write
    boot_up = 1'b0; cyc();
    boot_up = 1'b1; boot_len = 8'd0; cyc();
    load_words(256, 32'h1000);
    chk("len256_ready_low", 40'(boot_ready), 40'(1'b0));
    wait_run("len256_run", 10);
    boot_valid = 1'b0;

    // Watchdog: 1023-cycle gap tolerated, 1024-cycle gap errors
    boot_up = 1'b0; cyc();
    boot_up = 1'b1; boot_len = 8'd3; cyc();
    load_words(1, 32'hC0);
    boot_valid = 1'b0;
    for (int i = 0; i < 1023; i++) cyc();
    chk("gap1023_ok", 40'(outs()), 40'(6'b110000));
    boot_valid = 1'b1; boot_data = 32'hC1; sb_q.push_back({8'd1, 32'hC1}); cyc();
    boot_valid = 1'b0;
    for (int i = 0; i < 1023; i++) cyc();
    chk("gap1024_pre", 40'(err), 40'(1'b0));
    cyc();
    chk("gap1024_err", 40'(outs()), 40'(6'b010001));
    boot_up = 1'b0; cyc();
    chk("err_clear_idle", 40'(outs()), 40'(6'b010000));

    // Abort coinciding with the final transfer
    boot_up = 1'b1; boot_len = 8'd2; cyc();
    load_words(1, 32'hD0);
    boot_up = 1'b0; boot_valid = 1'b1; boot_data = 32'hD1; cyc();
    chk("abort_last", 40'(outs()), 40'(6'b010000));
    boot_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("abort_stays_idle", 40'(outs()), 40'(6'b010000));

    // Reset mid-LOAD, with a transfer pending in the same cycle
    boot_up = 1'b1; boot_len = 8'd5; cyc();
    load_words(2, 32'hE0);
    rst = 1'b1; boot_valid = 1'b1; boot_data = 32'hE2; cyc();
    chk("midload_rst_outs", 40'(outs()), 40'(6'b010000));
    chk("midload_rst_addr_data", {imem_addr, imem_datai}, 40'h0);
    rst = 1'b0; boot_valid = 1'b0; cyc();
    chk("post_rst_no_boot", 40'(outs()), 40'(6'b010000));
    boot_up = 1'b0; cyc();
    boot_up = 1'b1; boot_len = 8'd1; cyc();
    load_words(1, 32'hF0);
    boot_valid = 1'b0;
    wait_run("post_rst_boot_run", 10);

    chk("scoreboard_drained", 40'(sb_q.size()), 40'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boot_seq.md
BOOT_SEQ -- requirements
Module: boot_seq

Interface
REQ-001 The interface SHALL have one clock and a synchronous, active-high reset: clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-002 Inputs SHALL be: boot_up (1, level request to boot), boot_len (8, word count latched at boot start, 0 encodes 256), boot_valid (1, boot word present), boot_data (32, instruction word).
REQ-003 Outputs SHALL be: boot_ready (1, loader accepts word), imem_web (1, active-low instruction SRAM write enable), imem_addr (8, SRAM word address), imem_datai (32, SRAM write data), core_rst_n (1, active-low core reset), PC_run (1, core fetch enable), done (1, boot complete), err (1, boot timeout).
REQ-004 All outputs SHALL be driven from registers.

Function
REQ-005 States SHALL be IDLE, LOAD, FLUSH, RUN, ERR.
REQ-006 A boot start SHALL be a boot_up rising edge: boot_up high in the current cycle and low in the previous cycle, using a registered copy of boot_up.
REQ-007 On a boot start from IDLE or RUN, the block SHALL go to LOAD, latch boot_len, clear the word counter, and clear done, PC_run and core_rst_n on the next edge.
REQ-008 In LOAD, boot_ready SHALL be 1, and a transfer SHALL occur when boot_valid and boot_ready are both 1.
REQ-009 A transfer at edge k SHALL produce imem_web=0, imem_addr=counter and imem_datai=boot_data for exactly the cycle after edge k, then imem_web=1 unless another transfer occurs.
REQ-010 Back-to-back transfers SHALL sustain 1 word/cycle.
REQ-011 The word counter SHALL be 9-bit, and imem_addr SHALL be its low 8 bits.
REQ-012 LOAD SHALL end on the transfer where the counter equals the latched length minus 1 (255 for a latched 0, i.e. 256 words); boot_ready SHALL be 0 from the next cycle.
REQ-013 After the last transfer, the block SHALL enter FLUSH for FLUSH_CYC=2 cycles with imem_web=1, then enter RUN.
REQ-014 In RUN, core_rst_n, PC_run and done SHALL all be 1.
REQ-015 In LOAD, an idle counter SHALL clear on each transfer and increment otherwise; when it reaches TIMEOUT_CYC=1024, the block SHALL go to ERR.
REQ-016 In ERR, err SHALL be 1, core_rst_n=0, PC_run=0 and boot_ready=0; the block SHALL return to IDLE when boot_up=0, clearing err.
REQ-017 If boot_up=0 during LOAD or FLUSH (abort), the block SHALL return to IDLE with the core held in reset and no further SRAM writes; abort SHALL take priority over a simultaneous last transfer or timeout.
REQ-018 In RUN, boot_up falling SHALL have no effect; only a new rising edge SHALL re-boot.
REQ-019 In IDLE, core_rst_n SHALL be 0 and PC_run SHALL be 0.

Reset
REQ-020 rst=1 SHALL force the following state on the next edge: IDLE, boot_ready=0, imem_web=1, imem_addr=0, imem_datai=0, core_rst_n=0, PC_run=0, done=0, err=0, counters=0, registered boot_up=0.
REQ-021 rst SHALL override all other inputs, including mid-LOAD, where it SHALL suppress any pending SRAM write.
REQ-022 A boot_up held high through reset release SHALL NOT start a boot; a boot SHALL start only on a subsequent rising edge.

Structure
REQ-023 The state encoding, FLUSH_CYC, TIMEOUT_CYC and the address width (8) SHALL reside in the shared package boot_pkg.
REQ-024 The idle/timeout counter SHALL be a sub-module boot_wdt with inputs clr and en and output expired.

Verification
REQ-025 Reset then boot_up rise with boot_len=4 and valid held high, data 0x11..0x44 -> writes at addr 0..3 on 4 consecutive cycles; boot_ready low after the 4th transfer; core_rst_n=PC_run=done=1 exactly 3 cycles after the last write cycle.
REQ-026 boot_len=0 with 256 words streamed -> addresses 0..255 written, no wrap write, RUN reached.
REQ-027 boot_len=3 with a 1023-cycle valid gap -> no error; with a 1024-cycle gap -> err=1, ERR state; boot_up low -> err=0, IDLE.
REQ-028 boot_up dropped in the same cycle as the final transfer -> IDLE, no write for that word, done=0, core_rst_n=0.
REQ-029 RUN, then a new boot_up rising edge with boot_len=2 -> PC_run and core_rst_n fall next cycle, 2 words reloaded, RUN re-entered.
REQ-030 rst asserted mid-LOAD after 2 of 5 words -> all REQ-020 values; the next boot starts at addr 0.
